// File: rtl/cpu_pkg.sv
// Shared CPU constants and the boot loader state encoding.
// Optional checksum support in the loader is enabled with LOADER_CHECKSUM_EN.
package cpu_pkg;

  localparam int unsigned INST_ADDR_WIDTH = 8;
  localparam int unsigned INST_DATA_WIDTH = 32;
  localparam int unsigned LDR_LEN_WIDTH   = 16;
  localparam int unsigned BYTE_WIDTH      = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERR
  } loader_state_t;

  // States in which the loader accepts stream bytes.
  function automatic logic is_receiving(input loader_state_t s);
    return s inside {LEN_LO, LEN_HI, DATA, CHK};
  endfunction

  function automatic logic is_busy(input loader_state_t s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Assembles little-endian bytes into a 32-bit instruction word.
// word_valid_c flags the byte that completes the word.
module byte_word_packer
  import cpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [BYTE_WIDTH-1:0]      in_data,
  output logic [INST_DATA_WIDTH-1:0] word,
  output logic                       word_valid_c
);

  logic [1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      word  <= '0;
    end else if (clear) begin
      idx_q <= '0;
    end else if (in_valid) begin
      word[{idx_q, 3'b000} +: BYTE_WIDTH] <= in_data;
      idx_q                               <= idx_q + 2'd1;
    end
  end

  assign word_valid_c = in_valid && (idx_q == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: parses a length header, packs bytes into words, writes the instruction SRAM.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module inst_mem_loader
  import cpu_pkg::*;
#(
  parameter int unsigned INST_ADDR_WIDTH = cpu_pkg::INST_ADDR_WIDTH,
  parameter int unsigned INST_DATA_WIDTH = cpu_pkg::INST_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       s_valid,
  input  logic [7:0]                 s_data,
  output logic                       s_ready,
  output logic                       inst_sram_wr,
  output logic [INST_ADDR_WIDTH-1:0] inst_sram_addr,
  output logic [INST_DATA_WIDTH-1:0] inst_sram_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic                       core_run
);

  localparam int unsigned ADDR_CNT_WIDTH = INST_ADDR_WIDTH + 1;
  localparam int unsigned DEPTH          = 1 << INST_ADDR_WIDTH;

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = CHK;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  loader_state_t              state_q, state_d;
  logic                       xfer_c;
  logic                       start_acc_c;
  logic                       word_valid_c;
  logic                       last_word_c;
  logic [7:0]                 len_lo_q;
  logic [LDR_LEN_WIDTH-1:0]   len_full_c;
  logic [LDR_LEN_WIDTH-1:0]   words_rem_q;
  logic [ADDR_CNT_WIDTH-1:0]  addr_q;
  logic                       unused_addr_msb;

  assign xfer_c          = s_valid & s_ready;
  assign start_acc_c     = start && (state_q inside {IDLE, DONE, ERR});
  assign len_full_c      = {s_data, len_lo_q};
  assign last_word_c     = (words_rem_q == LDR_LEN_WIDTH'(1));
  assign inst_sram_addr  = addr_q[INST_ADDR_WIDTH-1:0];
  // Extra counter bit only exists so a full-depth image never wraps onto address 0.
  assign unused_addr_msb = addr_q[INST_ADDR_WIDTH];

  byte_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (start_acc_c),
    .in_valid     (xfer_c && (state_q == DATA)),
    .in_data      (s_data),
    .word         (inst_sram_data),
    .word_valid_c (word_valid_c)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (start_acc_c) begin
      csum_q <= '0;
    end else if (xfer_c && (state_q == DATA)) begin
      csum_q <= csum_q ^ s_data;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start) state_d = LEN_LO;
      LEN_LO:          if (xfer_c) state_d = LEN_HI;
      LEN_HI: begin
        if (xfer_c) begin
          if (len_full_c == '0)               state_d = END_STATE;
          else if (32'(len_full_c) > DEPTH)   state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA:            if (word_valid_c) state_d = WRITE;
      WRITE:           state_d = last_word_c ? END_STATE : DATA;
`ifdef LOADER_CHECKSUM_EN
      CHK:             if (xfer_c) state_d = (s_data == csum_q) ? DONE : ERR;
`endif
      default:         state_d = IDLE;
    endcase
  end

  // State register with outputs decoded from the next state so they are all flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_ready      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      core_run     <= 1'b0;
      inst_sram_wr <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_ready      <= is_receiving(state_d);
      busy         <= is_busy(state_d);
      done         <= (state_d == DONE);
      err          <= (state_d == ERR);
      core_run     <= (state_d == DONE);
      inst_sram_wr <= (state_d == WRITE);
    end
  end

  // Header latch, word counter and write address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_lo_q    <= '0;
      words_rem_q <= '0;
      addr_q      <= '0;
    end else if (start_acc_c) begin
      words_rem_q <= '0;
      addr_q      <= '0;
    end else begin
      case (state_q)
        LEN_LO: if (xfer_c) len_lo_q <= s_data;
        LEN_HI: if (xfer_c) words_rem_q <= len_full_c;
        WRITE: begin
          addr_q      <= addr_q + ADDR_CNT_WIDTH'(1);
          words_rem_q <= words_rem_q - LDR_LEN_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with an SRAM write monitor.
// Honours LOADER_CHECKSUM_EN by appending the XOR checksum byte to each image.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        inst_sram_wr;
  logic [7:0]  inst_sram_addr;
  logic [31:0] inst_sram_data;
  logic        busy, done, err, core_run;

  always #5 clk = ~clk;

  inst_mem_loader #(.INST_ADDR_WIDTH(8), .INST_DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .inst_sram_wr   (inst_sram_wr),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_data (inst_sram_data),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .core_run       (core_run)
  );

  logic [31:0] mem [0:255];
  int          wcount = 0;
  logic [7:0]  last_addr = 8'h00;

  always @(posedge clk) begin
    if (inst_sram_wr) begin
      mem[inst_sram_addr] <= inst_sram_data;
      wcount              <= wcount + 1;
      last_addr           <= inst_sram_addr;
    end
  end

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] img [0:255];
  logic [7:0]  csum_flip = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Transfer one byte; returns at posedge+1 of the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    s_valid = 1'b0;
    if (!ok) check("byte_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic set_img1();
    img[0] = 32'h12345678;
    img[1] = 32'hDEADBEEF;
  endtask

  // Full load from start pulse until busy drops.
  task automatic load(input logic [15:0] len, input int stall_byte, input bit strobe_chk);
    logic [7:0] b;
    int         c0;
    bit         idle_ok = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
`endif
    pulse_start();
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int w = 0; w < int'(len); w++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[w][8*k +: 8];
        if (w == 0 && k == stall_byte) begin
          c0 = wcount;
          repeat (3) @(posedge clk);
          #1;
          pulse_start();
          repeat (3) @(posedge clk);
          #1;
          check("stall_ready", {31'b0, s_ready}, 32'd1);
          check("stall_busy", {31'b0, busy}, 32'd1);
          check("stall_no_write", 32'(wcount - c0), 32'd0);
        end
        send_byte(b);
`ifdef LOADER_CHECKSUM_EN
        cs ^= b;
`endif
      end
      if (strobe_chk) begin
        check("wr_strobe", {31'b0, inst_sram_wr}, 32'd1);
        check("wr_addr", {24'b0, inst_sram_addr}, 32'(w));
        check("wr_data", inst_sram_data, img[w]);
        @(posedge clk);
        #1;
        check("wr_one_cycle", {31'b0, inst_sram_wr}, 32'd0);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs ^ csum_flip);
`endif
    for (int i = 0; i < 10 && !idle_ok; i++) begin
      if (!busy) idle_ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!idle_ok) check("load_timeout", {31'b0, idle_ok}, 32'd1);
  endtask

  initial begin
    int c0;
    int errs;
    #1;
    check("reset_outputs", {26'b0, s_ready, inst_sram_wr, busy, done, err, core_run}, 32'd0);
    check("reset_addr", {24'b0, inst_sram_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-word image with per-word strobe checks.
    set_img1();
    c0 = wcount;
    load(16'd2, -1, 1'b1);
    check("t1_done", {29'b0, done, core_run, busy}, 32'b110);
    check("t1_writes", 32'(wcount - c0), 32'd2);
    check("t1_mem0", mem[0], 32'h12345678);
    check("t1_mem1", mem[1], 32'hDEADBEEF);

    // Same image with a 7-cycle stall (and an ignored start) inside word 0.
    mem[0] = 32'h0;
    mem[1] = 32'h0;
    c0 = wcount;
    load(16'd2, 2, 1'b1);
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_writes", 32'(wcount - c0), 32'd2);
    check("t2_mem0", mem[0], 32'h12345678);
    check("t2_mem1", mem[1], 32'hDEADBEEF);

    // Oversize header: start from DONE drops core_run at once, then ERR.
    c0 = wcount;
    pulse_start();
    check("t3_run_drop", {30'b0, core_run, busy}, 32'b01);
    send_byte(8'h01);
    send_byte(8'h01);
    check("t3_err", {28'b0, err, core_run, busy, s_ready}, 32'b1000);
    repeat (3) @(posedge clk);
    #1;
    check("t3_err_sticky", {30'b0, err, done}, 32'b10);
    check("t3_no_write", 32'(wcount - c0), 32'd0);
    set_img1();
    load(16'd2, -1, 1'b0);
    check("t3_restart", {29'b0, done, err, core_run}, 32'b101);
    check("t3_restart_mem1", mem[1], 32'hDEADBEEF);

    // Zero-length image completes immediately.
    c0 = wcount;
    load(16'd0, -1, 1'b0);
    check("len0_done", {29'b0, done, err, core_run}, 32'b101);
    check("len0_no_write", 32'(wcount - c0), 32'd0);

    // Full-depth image: 256 words, no wrap onto address 0.
    for (int i = 0; i < 256; i++) img[i] = {8'(i), ~8'(i), 8'h5A, 8'(i)};
    c0 = wcount;
    load(16'h0100, -1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    errs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) errs++;
    check("t4_done", {31'b0, done}, 32'd1);
    check("t4_writes", 32'(wcount - c0), 32'd256);
    check("t4_last_addr", {24'b0, last_addr}, 32'h000000FF);
    check("t4_mem_errs", 32'(errs), 32'd0);
    check("t4_mem0_kept", mem[0], 32'h00FF5A00);

    // Asynchronous reset after five data bytes of a two-word load.
    img[0] = 32'hA1B2C3D4;
    img[1] = 32'h0BADF00D;
    mem[1] = 32'h0;
    c0 = wcount;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8]);
    send_byte(8'h0D);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {26'b0, s_ready, inst_sram_wr, busy, done, err, core_run}, 32'd0);
    check("t5_rst_bus", {inst_sram_data[23:0], inst_sram_addr}, 32'd0);
    check("t5_partial_writes", 32'(wcount - c0), 32'd1);
    check("t5_mem0", mem[0], 32'hA1B2C3D4);
    check("t5_mem1_untouched", mem[1], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    img[0] = 32'h01020304;
    img[1] = 32'hCAFEF00D;
    load(16'd2, -1, 1'b1);
    check("t5_reload_done", {29'b0, done, err, core_run}, 32'b101);
    check("t5_reload_mem1", mem[1], 32'hCAFEF00D);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum aborts; a zero-length image needs checksum 0x00.
    set_img1();
    csum_flip = 8'h01;
    load(16'd2, -1, 1'b0);
    check("t6_bad_csum", {29'b0, done, err, core_run}, 32'b010);
    csum_flip = 8'h00;
    load(16'd0, -1, 1'b0);
    check("t6_len0_csum", {29'b0, done, err, core_run}, 32'b101);
    load(16'd2, -1, 1'b0);
    check("t6_good_csum", {29'b0, done, err, core_run}, 32'b101);
    pulse_start();
    check("t6_run_drop", {30'b0, core_run, busy}, 32'b01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
